// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA link receive stage.
// Optional feature macro: FPGA_RX_PARITY_EN (adds one even-parity bit per frame).
package fpga_link_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

`ifdef FPGA_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_RECV     = 3'd2,
        ST_WAIT_FIN = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_REL = 3'd5
    } rx_state_e;

endpackage

// File: rtl/fpga_receiver_if.sv
// Handshake and data bundle between the link transmitter/local logic and the receiver.
interface fpga_receiver_if
    import fpga_link_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  reqIn;
    logic                  serialIn;
    logic                  finishIn;
    logic                  acknowledge;
    logic                  sent;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  frameErr;

    modport slave (
        input  reqIn, serialIn, finishIn,
        output acknowledge, sent, dataOut, dataValid, frameErr
    );

    modport master (
        output reqIn, serialIn, finishIn,
        input  acknowledge, sent, dataOut, dataValid, frameErr
    );
endinterface

// File: rtl/fpga_receiver_shift.sv
// Serial-in / parallel-out shift register, MSB arrives first.
module rx_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] shift_q;

    // Shift state: clear has priority over shifting a new bit in at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
        end else if (en_i) begin
            shift_q <= {shift_q[WIDTH-2:0], bit_i};
        end else begin
            shift_q <= shift_q;
        end
    end

    assign data_o = shift_q;
endmodule

// File: rtl/fpga_receiver.sv
// Receive side of the FPGA-to-FPGA link: handshake FSM, bit counter, output registers.
// Optional feature macro: FPGA_RX_PARITY_EN (frame carries a trailing even-parity bit).
module fpga_receiver
    import fpga_link_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fpga_receiver_if.slave link
);
    localparam int SHIFT_W = DATA_WIDTH + PARITY_BITS;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ack_q, ack_d;
    logic                  sent_q, sent_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    logic                  shift_en_s;
    logic                  shift_clr_s;
    logic [SHIFT_W-1:0]    shift_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  frame_ok_s;
    logic                  violation_s;

`ifdef FPGA_RX_PARITY_EN
    // True when the frame (data plus parity bit) holds an even number of ones.
    function automatic logic even_parity_ok(input logic [SHIFT_W-1:0] frame);
        return ~(^frame);
    endfunction

    assign data_s     = shift_s[SHIFT_W-1:1];
    assign frame_ok_s = even_parity_ok(shift_s);
`else
    assign data_s     = shift_s;
    assign frame_ok_s = 1'b1;
`endif

    // A finish strobe or a dropped request before the word is complete aborts the frame.
    assign violation_s = link.finishIn | ~link.reqIn;

    rx_shift_register #(.WIDTH(SHIFT_W)) u_shift (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (shift_clr_s),
        .en_i   (shift_en_s),
        .bit_i  (link.serialIn),
        .data_o (shift_s)
    );

    // Next-state, counter and next-output decode; pulses are set on entry to their state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        ack_d       = 1'b0;
        sent_d      = 1'b0;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        shift_en_s  = 1'b0;
        shift_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (link.reqIn) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                cnt_d       = '0;
                shift_clr_s = 1'b1;
                if (violation_s) begin
                    ferr_d  = 1'b1;
                    state_d = link.reqIn ? ST_WAIT_REL : ST_IDLE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (violation_s) begin
                    ferr_d  = 1'b1;
                    state_d = link.reqIn ? ST_WAIT_REL : ST_IDLE;
                end else begin
                    shift_en_s = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SHIFT_W - 1)) begin
                        state_d = ST_WAIT_FIN;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_WAIT_FIN: begin
                if (!link.reqIn) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (link.finishIn) begin
                    if (frame_ok_s) begin
                        state_d = ST_DONE;
                        dout_d  = data_s;
                        sent_d  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_REL;
                    end
                end else begin
                    state_d = ST_WAIT_FIN;
                end
            end
            ST_DONE: begin
                state_d = link.reqIn ? ST_WAIT_REL : ST_IDLE;
            end
            ST_WAIT_REL: begin
                if (!link.reqIn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts everything with no pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            sent_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            sent_q  <= sent_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign link.acknowledge = ack_q;
    assign link.sent        = sent_q;
    assign link.dataValid   = valid_q;
    assign link.frameErr    = ferr_q;
    assign link.dataOut     = dout_q;
endmodule

// File: tb/tb_fpga_receiver.sv
// Self-checking bench for fpga_receiver: transfer-level model plus per-cycle compare.
module tb_fpga_receiver;
    localparam int DW = 8;
`ifdef FPGA_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = DW + PB;

    logic clk = 1'b0;
    logic reset;

    fpga_receiver_if #(.DATA_WIDTH(DW)) link ();

    fpga_receiver #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic check_en = 1'b0;
    logic e_ack, e_done, e_ferr;
    logic [DW-1:0] e_dout;
    logic [DW-1:0] model_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model's expectation.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("acknowledge", 32'(link.acknowledge), 32'(e_ack));
            chk("sent",        32'(link.sent),        32'(e_done));
            chk("dataValid",   32'(link.dataValid),   32'(e_done));
            chk("frameErr",    32'(link.frameErr),    32'(e_ferr));
            chk("dataOut",     32'(link.dataOut),     32'(e_dout));
        end
    end

    // One cycle: drive inputs, record what must appear after the next rising edge.
    task automatic step(input logic req, input logic ser, input logic fin,
                        input logic a, input logic d, input logic f);
        @(negedge clk);
        link.reqIn    = req;
        link.serialIn = ser;
        link.finishIn = fin;
        e_ack  = a;
        e_done = d;
        e_ferr = f;
        e_dout = model_dout;
        @(posedge clk);
    endtask

    // Full transfer; flip corrupts the parity bit (parity build only), hold keeps req high after finish.
    task automatic xfer(input logic [DW-1:0] word, input logic flip, input int hold);
        logic [NB-1:0] frame;
`ifdef FPGA_RX_PARITY_EN
        frame = {word, (^word) ^ flip};
`else
        frame = word;
`endif
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = NB - 1; i >= 0; i--) step(1'b1, frame[i], 1'b0, 1'b0, 1'b0, 1'b0);
        if (!flip) model_dout = word;
        step(1'b1, 1'b0, 1'b1, 1'b0, !flip, flip);
        for (int i = 0; i < hold; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Aborted transfer: kind 1 = early finish, kind 2 = request dropped.
    task automatic abort_xfer(input logic [DW-1:0] word, input int nbits, input int kind);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) step(1'b1, word[DW-1-i], 1'b0, 1'b0, 1'b0, 1'b0);
        if (kind == 1) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset         = 1'b0;
        link.reqIn    = 1'b0;
        link.serialIn = 1'b0;
        link.finishIn = 1'b0;
        model_dout    = '0;
        e_ack  = 1'b0;
        e_done = 1'b0;
        e_ferr = 1'b0;
        e_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'(link.acknowledge), 32'd0);
        chk("rst_sent",  32'(link.sent),        32'd0);
        chk("rst_valid", 32'(link.dataValid),   32'd0);
        chk("rst_ferr",  32'(link.frameErr),    32'd0);
        chk("rst_dout",  32'(link.dataOut),     32'd0);
        @(negedge clk);
        reset    = 1'b1;
        check_en = 1'b1;

        abort_xfer(8'hA5, 4, 1);
        #2 chk("early_fin_dout", 32'(link.dataOut), 32'h00);

        xfer(8'hA5, 1'b0, 0);
        #2 chk("nominal_dout", 32'(link.dataOut), 32'hA5);

        xfer(8'h3C, 1'b0, 3);
        #2 chk("b2b_first_dout", 32'(link.dataOut), 32'h3C);
        xfer(8'hC3, 1'b0, 0);
        #2 chk("b2b_second_dout", 32'(link.dataOut), 32'hC3);

        abort_xfer(8'h5A, 5, 2);
        #2 chk("req_drop_dout", 32'(link.dataOut), 32'hC3);
        xfer(8'hFF, 1'b0, 0);
        #2 chk("after_drop_dout", 32'(link.dataOut), 32'hFF);

        // Reset asserted asynchronously after three bits of a transfer.
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check_en = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_ack",   32'(link.acknowledge), 32'd0);
        chk("midrst_sent",  32'(link.sent),        32'd0);
        chk("midrst_valid", 32'(link.dataValid),   32'd0);
        chk("midrst_ferr",  32'(link.frameErr),    32'd0);
        chk("midrst_dout",  32'(link.dataOut),     32'd0);
        model_dout = '0;
        @(negedge clk);
        link.reqIn    = 1'b0;
        link.serialIn = 1'b0;
        link.finishIn = 1'b0;
        e_ack  = 1'b0;
        e_done = 1'b0;
        e_ferr = 1'b0;
        e_dout = '0;
        reset    = 1'b1;
        check_en = 1'b1;
        xfer(8'h01, 1'b0, 0);
        #2 chk("post_reset_dout", 32'(link.dataOut), 32'h01);

`ifdef FPGA_RX_PARITY_EN
        xfer(8'h07, 1'b0, 0);
        #2 chk("parity_good_dout", 32'(link.dataOut), 32'h07);
        xfer(8'h07, 1'b1, 1);
        #2 chk("parity_bad_dout", 32'(link.dataOut), 32'h07);
`endif

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
